dtfag_rom_fetch: RTL and testbench



---
 rtl/dtfag_rom_fetch_if.sv | 37 +++
 rtl/dtfag_rom_fetch.sv | 173 +++++++++++++++++
 tb/tb_dtfag_rom_fetch.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dtfag_rom_fetch_if.sv
// Twiddle-ROM fetch bus: stage control, shared ROM read port for the 8 banks,
// and the valid/ready output toward the decompose stage.
interface dtfag_rom_fetch_if #(
  parameter int ADDR_W         = 12,
  parameter int doulbe_D_width = 32
);
  logic                      start;
  logic [1:0]                stage;
  logic                      busy;
  logic                      done;
  logic                      rom_re;
  logic [ADDR_W-1:0]         rom_addr;
  logic [doulbe_D_width-1:0] ROM_b0b1_rdata,  ROM_b2b3_rdata,  ROM_b4b5_rdata,  ROM_b6b7_rdata;
  logic [doulbe_D_width-1:0] ROM_b8b9_rdata,  ROM_b10b11_rdata, ROM_b12b13_rdata, ROM_b14b15_rdata;
  logic [doulbe_D_width-1:0] ROM_b0b1_Q,  ROM_b2b3_Q,  ROM_b4b5_Q,  ROM_b6b7_Q;
  logic [doulbe_D_width-1:0] ROM_b8b9_Q,  ROM_b10b11_Q, ROM_b12b13_Q, ROM_b14b15_Q;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    input  start, stage, out_ready,
           ROM_b0b1_rdata, ROM_b2b3_rdata, ROM_b4b5_rdata, ROM_b6b7_rdata,
           ROM_b8b9_rdata, ROM_b10b11_rdata, ROM_b12b13_rdata, ROM_b14b15_rdata,
    output busy, done, rom_re, rom_addr, out_valid,
           ROM_b0b1_Q, ROM_b2b3_Q, ROM_b4b5_Q, ROM_b6b7_Q,
           ROM_b8b9_Q, ROM_b10b11_Q, ROM_b12b13_Q, ROM_b14b15_Q
  );

  modport slave (
    output start, stage, out_ready,
           ROM_b0b1_rdata, ROM_b2b3_rdata, ROM_b4b5_rdata, ROM_b6b7_rdata,
           ROM_b8b9_rdata, ROM_b10b11_rdata, ROM_b12b13_rdata, ROM_b14b15_rdata,
    input  busy, done, rom_re, rom_addr, out_valid,
           ROM_b0b1_Q, ROM_b2b3_Q, ROM_b4b5_Q, ROM_b6b7_Q,
           ROM_b8b9_Q, ROM_b10b11_Q, ROM_b12b13_Q, ROM_b14b15_Q
  );
endinterface

// File: rtl/dtfag_rom_fetch.sv
// Twiddle-ROM fetch controller: walks the group counter of one FFT stage, reads
// 8 ROM banks, buffers words in a 2-entry skid FIFO. Option: DTFAG_FETCH_STALL_CNT_EN.

module dtfag_fetch_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         wr_ptr,
  input  logic         rd_ptr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [1:0][W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  assign dout = mem_q[rd_ptr];
endmodule

module dtfag_rom_fetch #(
  parameter int ADDR_W         = 12,
  parameter int ROM_LAT        = 1,
  parameter int doulbe_D_width = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dtfag_rom_fetch_if.master bus
`ifdef DTFAG_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int NB = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              grp_cnt_q, grp_cnt_d;
  logic [1:0]                     stage_q, stage_d;
  logic                           inflight_q;
  logic [1:0]                     fifo_cnt_q, fifo_cnt_d;
  logic                           wr_ptr_q, rd_ptr_q;
  logic                           push, pop, issue, start_acc, done;
  logic [2:0]                     credit;
  logic [NB-1:0][doulbe_D_width-1:0] rdata, head;

  assign start_acc = (state_q == IDLE) && bus.start;
  assign push      = inflight_q;
  assign pop       = (fifo_cnt_q != 2'd0) && bus.out_ready;
  // Occupancy the FIFO will have once everything already requested has landed.
  assign credit    = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == RUN) && (credit < 3'd2);

  always_comb begin
    state_d   = state_q;
    grp_cnt_d = grp_cnt_q;
    stage_d   = stage_q;
    done      = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d   = RUN;
        grp_cnt_d = '0;
        stage_d   = bus.stage;
      end
      RUN: if (issue) begin
        grp_cnt_d = grp_cnt_q + 1'b1;
        if (&grp_cnt_q) state_d = DRAIN;
      end
      DRAIN: if (fifo_cnt_q == 2'd0 && !inflight_q) begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 2'd1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grp_cnt_q  <= '0;
      stage_q    <= 2'd0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grp_cnt_q  <= grp_cnt_d;
      stage_q    <= stage_d;
      inflight_q <= issue;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_q ^ pop;
    end
  end

  assign rdata[0] = bus.ROM_b0b1_rdata;
  assign rdata[1] = bus.ROM_b2b3_rdata;
  assign rdata[2] = bus.ROM_b4b5_rdata;
  assign rdata[3] = bus.ROM_b6b7_rdata;
  assign rdata[4] = bus.ROM_b8b9_rdata;
  assign rdata[5] = bus.ROM_b10b11_rdata;
  assign rdata[6] = bus.ROM_b12b13_rdata;
  assign rdata[7] = bus.ROM_b14b15_rdata;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    dtfag_fetch_lane #(.W(doulbe_D_width)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push),
      .wr_ptr (wr_ptr_q),
      .rd_ptr (rd_ptr_q),
      .din    (rdata[i]),
      .dout   (head[i])
    );
  end

  assign bus.ROM_b0b1_Q   = head[0];
  assign bus.ROM_b2b3_Q   = head[1];
  assign bus.ROM_b4b5_Q   = head[2];
  assign bus.ROM_b6b7_Q   = head[3];
  assign bus.ROM_b8b9_Q   = head[4];
  assign bus.ROM_b10b11_Q = head[5];
  assign bus.ROM_b12b13_Q = head[6];
  assign bus.ROM_b14b15_Q = head[7];

  // Stage 3 shifts every group bit out, leaving the W^0 row at address 0.
  assign bus.rom_addr  = grp_cnt_q << {stage_q, 2'b00};
  assign bus.rom_re    = issue;
  assign bus.out_valid = (fifo_cnt_q != 2'd0);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done;

`ifdef DTFAG_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc)
      stall_cnt_d = 16'd0;
    else if (bus.out_valid && !bus.out_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_cnt_q == 2'd2));
  rom_lat_supported: assert property (@(posedge clk) disable iff (!rst_n)
    ROM_LAT == 1);
endmodule

// File: tb/tb_dtfag_rom_fetch.sv
// Randomized bench for dtfag_rom_fetch: ROM model returns (bank<<16)|addr, a
// reference list of expected per-group addresses/words is rebuilt from the stage stride.
module tb_dtfag_rom_fetch;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dtfag_rom_fetch_if #(.ADDR_W(AW), .doulbe_D_width(DW)) bus ();
`ifdef DTFAG_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  dtfag_rom_fetch #(.ADDR_W(AW), .ROM_LAT(1), .doulbe_D_width(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DTFAG_FETCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // ROM banks, one cycle of read latency
  logic [7:0][DW-1:0] rom_q;
  always @(posedge clk)
    if (bus.rom_re)
      for (int k = 0; k < 8; k++) rom_q[k] <= DW'((k << 16) | int'(bus.rom_addr));
  assign bus.ROM_b0b1_rdata   = rom_q[0];
  assign bus.ROM_b2b3_rdata   = rom_q[1];
  assign bus.ROM_b4b5_rdata   = rom_q[2];
  assign bus.ROM_b6b7_rdata   = rom_q[3];
  assign bus.ROM_b8b9_rdata   = rom_q[4];
  assign bus.ROM_b10b11_rdata = rom_q[5];
  assign bus.ROM_b12b13_rdata = rom_q[6];
  assign bus.ROM_b14b15_rdata = rom_q[7];

  int n_pass = 0, n_total = 0;

  logic [AW-1:0]   obs_addr[$];
  logic [8*DW-1:0] obs_entry[$];
  int busy_cyc, done_cyc, first_re_k, first_vld_k, head_unstable, stall_seen;
  int stall_reads, stall_last_re, timed_out;

  function automatic logic [8*DW-1:0] head();
    return {bus.ROM_b14b15_Q, bus.ROM_b12b13_Q, bus.ROM_b10b11_Q, bus.ROM_b8b9_Q,
            bus.ROM_b6b7_Q,   bus.ROM_b4b5_Q,   bus.ROM_b2b3_Q,   bus.ROM_b0b1_Q};
  endfunction

  function automatic logic [AW-1:0] exp_addr(int s, int g);
    return AW'(g * (1 << (4 * s)));
  endfunction

  function automatic logic [8*DW-1:0] exp_entry(logic [AW-1:0] a);
    logic [8*DW-1:0] e;
    for (int k = 0; k < 8; k++) e[k*DW +: DW] = DW'(k * 65536 + int'(a));
    return e;
  endfunction

  // mismatches of the observed read/output lists against the reference list
  function automatic int seq_errs(int s);
    int e = 0;
    if (obs_entry.size() != N || obs_addr.size() != N) return N;
    for (int g = 0; g < N; g++) begin
      if (obs_addr[g] !== exp_addr(s, g)) e++;
      if (obs_entry[g] !== exp_entry(exp_addr(s, g))) e++;
    end
    return e;
  endfunction

  task automatic run_stage(input logic [1:0] s, input int mode);
    int k = 0, win = -1;
    logic hold = 1'b0;
    logic [8*DW-1:0] held = '0;
    obs_addr.delete(); obs_entry.delete();
    busy_cyc = 0; done_cyc = 0; first_re_k = -1; first_vld_k = -1;
    head_unstable = 0; stall_seen = 0; stall_reads = -1; stall_last_re = -1; timed_out = 0;
    @(posedge clk); #1 bus.start = 1'b1; bus.stage = s; bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.stage = ~s;
    forever begin
      @(negedge clk); k++;
      if (bus.busy) busy_cyc++;
      if (bus.done) done_cyc++;
      if (bus.rom_re) begin
        if (first_re_k < 0) first_re_k = k;
        obs_addr.push_back(bus.rom_addr);
      end
      if (bus.out_valid && first_vld_k < 0) first_vld_k = k;
      if (hold && (!bus.out_valid || head() !== held)) head_unstable++;
      hold = bus.out_valid && !bus.out_ready;
      held = head();
      if (hold) stall_seen++;
      if (mode == 2 && win == 10) stall_last_re = int'(bus.rom_re);
      if (bus.out_valid && bus.out_ready) obs_entry.push_back(head());
      if (bus.done) break;
      if (k > 3 * N) begin timed_out = 1; break; end
      @(posedge clk); #1;
      case (mode)
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (win < 0 && obs_entry.size() == 50) win = 0;
          if (win >= 0 && win < 10) begin
            bus.out_ready = 1'b0; win++;
          end else begin
            if (win == 10) begin stall_reads = obs_addr.size() - obs_entry.size(); win = 11; end
            bus.out_ready = 1'b1;
          end
        end
        3: begin bus.start = (k == 20); bus.stage = 2'd1; end
        default: bus.out_ready = 1'b1;
      endcase
    end
    @(posedge clk); #1 bus.out_ready = 1'b1; bus.start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++; if ({bus.busy, bus.done, bus.rom_re, bus.out_valid} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {bus.busy, bus.done, bus.rom_re, bus.out_valid}); else n_pass++;
    n_total++; if (head() !== '0 || bus.rom_addr !== '0) $display("FAIL reset_data: head %h addr %0d want 0", head(), bus.rom_addr); else n_pass++;
`ifdef DTFAG_FETCH_STALL_CNT_EN
    n_total++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_stage0();
    int e;
    run_stage(2'd0, 0);
    e = seq_errs(0);
    n_total++; if (timed_out !== 0) $display("FAIL s0_timeout: got %0d want 0", timed_out); else n_pass++;
    n_total++; if (e !== 0) $display("FAIL s0_sequence: %0d errors, got %0d entries want %0d", e, obs_entry.size(), N); else n_pass++;
    n_total++; if (done_cyc !== 1) $display("FAIL s0_done_count: got %0d want 1", done_cyc); else n_pass++;
    n_total++; if (busy_cyc !== N + 3) $display("FAIL s0_busy_cycles: got %0d want %0d", busy_cyc, N + 3); else n_pass++;
    n_total++; if (first_re_k !== 1 || first_vld_k !== 3) $display("FAIL s0_latency: got re@%0d valid@%0d want 1 and 3", first_re_k, first_vld_k); else n_pass++;
`ifdef DTFAG_FETCH_STALL_CNT_EN
    n_total++; if (stall_cnt !== 16'd0) $display("FAIL s0_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
`endif
  endtask

  task automatic test_stage1();
    int e;
    run_stage(2'd1, 0);
    e = seq_errs(1);
    n_total++; if (e !== 0) $display("FAIL s1_sequence: %0d errors, got %0d entries", e, obs_entry.size()); else n_pass++;
    n_total++; if (obs_addr.size() != N || obs_addr[255] !== 12'd4080 || obs_addr[256] !== 12'd0) $display("FAIL s1_wrap: got %0d entries want 4080 then 0 at group 256", obs_addr.size()); else n_pass++;
  endtask

  task automatic test_stage3();
    int e;
    run_stage(2'd3, 0);
    e = seq_errs(3);
    n_total++; if (e !== 0) $display("FAIL s3_all_zero: %0d errors, got %0d entries", e, obs_entry.size()); else n_pass++;
    n_total++; if (done_cyc !== 1) $display("FAIL s3_done_count: got %0d want 1", done_cyc); else n_pass++;
  endtask

  task automatic test_backpressure();
    int e;
    run_stage(2'd0, 2);
    e = seq_errs(0);
    n_total++; if (e !== 0) $display("FAIL bp_sequence: %0d errors, got %0d entries", e, obs_entry.size()); else n_pass++;
    n_total++; if (stall_reads !== 2) $display("FAIL bp_reads_ahead: got %0d want 2", stall_reads); else n_pass++;
    n_total++; if (stall_last_re !== 0) $display("FAIL bp_re_low: got %0d want 0", stall_last_re); else n_pass++;
    n_total++; if (head_unstable !== 0 || stall_seen !== 10) $display("FAIL bp_head_hold: unstable %0d stalls %0d want 0 and 10", head_unstable, stall_seen); else n_pass++;
`ifdef DTFAG_FETCH_STALL_CNT_EN
    n_total++; if (stall_cnt !== 16'd10) $display("FAIL bp_stall_cnt: got %0d want 10", stall_cnt); else n_pass++;
`endif
  endtask

  task automatic test_random_ready();
    int e;
    run_stage(2'd0, 1);
    e = seq_errs(0);
    n_total++; if (timed_out !== 0) $display("FAIL rnd_timeout: got %0d want 0", timed_out); else n_pass++;
    n_total++; if (e !== 0) $display("FAIL rnd_sequence: %0d errors, got %0d entries", e, obs_entry.size()); else n_pass++;
    n_total++; if (head_unstable !== 0) $display("FAIL rnd_head_hold: got %0d want 0", head_unstable); else n_pass++;
    n_total++; if (done_cyc !== 1) $display("FAIL rnd_done_count: got %0d want 1", done_cyc); else n_pass++;
`ifdef DTFAG_FETCH_STALL_CNT_EN
    n_total++; if (int'(stall_cnt) !== (stall_seen > 65535 ? 65535 : stall_seen)) $display("FAIL rnd_stall_cnt: got %0d want %0d", stall_cnt, stall_seen); else n_pass++;
`endif
  endtask

  task automatic test_start_during_run();
    int e;
    run_stage(2'd0, 3);
    e = seq_errs(0);
    n_total++; if (e !== 0) $display("FAIL sdr_sequence: %0d errors, got %0d entries want %0d", e, obs_entry.size(), N); else n_pass++;
    n_total++; if (busy_cyc !== N + 3 || done_cyc !== 1) $display("FAIL sdr_busy_done: busy %0d done %0d want %0d and 1", busy_cyc, done_cyc, N + 3); else n_pass++;
  endtask

  task automatic test_reset_mid_stage();
    int pops = 0, k = 0, spur = 0, e;
    @(posedge clk); #1 bus.start = 1'b1; bus.stage = 2'd0; bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    while (pops < 100 && k < 1000) begin
      @(negedge clk); k++;
      if (bus.out_valid && bus.out_ready) pops++;
    end
    n_total++; if (pops !== 100) $display("FAIL rst_reach_100: got %0d want 100", pops); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    n_total++; if ({bus.busy, bus.done, bus.rom_re, bus.out_valid} !== 4'b0 || bus.rom_addr !== '0 || head() !== '0) $display("FAIL rst_outputs_zero: ctrl %b addr %0d head %h want 0", {bus.busy, bus.done, bus.rom_re, bus.out_valid}, bus.rom_addr, head()); else n_pass++;
`ifdef DTFAG_FETCH_STALL_CNT_EN
    n_total++; if (stall_cnt !== 16'd0) $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.out_valid || bus.busy || bus.rom_re) spur++;
    end
    n_total++; if (spur !== 0) $display("FAIL rst_spurious: got %0d want 0", spur); else n_pass++;
    run_stage(2'd0, 0);
    e = seq_errs(0);
    n_total++; if (e !== 0 || obs_addr[0] !== '0) $display("FAIL rst_clean_stage: %0d errors, %0d entries", e, obs_entry.size()); else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0; bus.stage = 2'd0; bus.out_ready = 1'b1; rst_n = 1'b0;
    test_reset();
    test_stage0();
    test_stage1();
    test_stage3();
    test_backpressure();
    test_random_ready();
    test_start_during_run();
    test_reset_mid_stage();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
